multicycle_ctrl: RTL and testbench

//  Control FSM that sequences the RV32I multicycle datapath: one shared memory port, with the ALU reused for PC+4 and branch targets.

---
 rtl/rv32i_pkg.sv | 90 +++++++++
 rtl/multicycle_ctrl_alu_decoder.sv | 38 +++
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multicycle control path:
// opcodes, ALU/mux select enums and the controller state set.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_RDATA  = 2'b01,
        RES_ALURES = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } srca_t;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } srcb_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JALR,
        S_JUMP,
        S_BRANCH,
        S_UPPER,
        S_TRAP
    } state_t;

    function automatic imm_src_t imm_src_of(logic [6:0] op);
        imm_src_t r;
        case (op)
            OP_STORE:        r = IMM_S;
            OP_BRANCH:       r = IMM_B;
            OP_JAL:          r = IMM_J;
            OP_LUI, OP_AUIPC: r = IMM_U;
            default:         r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU function decoder: maps funct3/funct7b5 to an ALU control code
// for R/I-type execution, or forces ADD/SUB for address and compare work.
module alu_decoder
    import rv32i_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    input  logic [1:0] alu_op,
    output logic [3:0] ALUControl
);

    alu_ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = ALU_ADD;
        case (alu_op_t'(alu_op))
            ALUOP_SUB: w_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: w_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: w_ctrl = ALU_SLL;
                    3'b010: w_ctrl = ALU_SLT;
                    3'b011: w_ctrl = ALU_SLTU;
                    3'b100: w_ctrl = ALU_XOR;
                    // funct7b5 splits SRL/SRA for both register and immediate shifts
                    3'b101: w_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: w_ctrl = ALU_OR;
                    default: w_ctrl = ALU_AND;
                endcase
            end
            default: w_ctrl = ALU_ADD;
        endcase
    end

    assign ALUControl = w_ctrl;

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the RV32I multicycle datapath with a shared memory port.
// Outputs are decoded from the current state; memory accesses stall on MemReady.
module multicycle_ctrl
    import rv32i_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       BrTaken,
    input  logic       MemReady,
    output logic       MemValid,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       Retire,
    output logic       Illegal
);

    state_t      r_state;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_is_br;
    logic        w_is_upper;

    alu_op_t     w_alu_op;
    logic [3:0]  w_alu_ctrl;
    logic        w_mv;
    logic        w_mw;
    logic        w_adr;
    logic        w_irw;
    logic        w_pcw;
    logic        w_rw;
    result_src_t w_rs;
    srca_t       w_sa;
    srcb_t       w_sb;
    logic        w_ret;

    assign w_is_load  = (op == OP_LOAD);
    assign w_is_store = (op == OP_STORE);
    assign w_is_r     = (op == OP_RTYPE);
    assign w_is_i     = (op == OP_ITYPE);
    assign w_is_jal   = (op == OP_JAL);
    assign w_is_jalr  = (op == OP_JALR);
    assign w_is_br    = (op == OP_BRANCH);
    assign w_is_upper = (op == OP_LUI) || (op == OP_AUIPC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:
                    if (MemReady) r_state <= S_DECODE;
                S_DECODE: begin
                    unique case (1'b1)
                        w_is_load,
                        w_is_store: r_state <= S_MEMADR;
                        w_is_r:     r_state <= S_EXECR;
                        w_is_i:     r_state <= S_EXECI;
                        w_is_jal:   r_state <= S_JUMP;
                        w_is_jalr:  r_state <= S_JALR;
                        w_is_br:    r_state <= S_BRANCH;
                        w_is_upper: r_state <= S_UPPER;
                        default:    r_state <= S_TRAP;
                    endcase
                end
                S_MEMADR:
                    r_state <= w_is_load ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:
                    if (MemReady) r_state <= S_MEMWB;
                S_MEMWRITE:
                    if (MemReady) r_state <= S_FETCH;
                S_EXECR,
                S_EXECI,
                S_UPPER,
                S_JUMP:     r_state <= S_ALUWB;
                S_JALR:     r_state <= S_JUMP;
                S_MEMWB,
                S_ALUWB,
                S_BRANCH:   r_state <= S_FETCH;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_mv     = 1'b0;
        w_mw     = 1'b0;
        w_adr    = 1'b0;
        w_irw    = 1'b0;
        w_pcw    = 1'b0;
        w_rw     = 1'b0;
        w_rs     = RES_ALUOUT;
        w_sa     = SRCA_PC;
        w_sb     = SRCB_RD2;
        w_alu_op = ALUOP_ADD;
        w_ret    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mv  = 1'b1;
                w_sb  = SRCB_FOUR;
                w_rs  = RES_ALURES;
                w_irw = MemReady;
                w_pcw = MemReady;
            end
            S_DECODE: begin
                w_sa = SRCA_OLDPC;
                w_sb = SRCB_IMM;
            end
            S_MEMADR,
            S_JALR: begin
                w_sa = SRCA_RD1;
                w_sb = SRCB_IMM;
            end
            S_MEMREAD: begin
                w_mv  = 1'b1;
                w_adr = 1'b1;
            end
            S_MEMWB: begin
                w_rs  = RES_RDATA;
                w_rw  = 1'b1;
                w_ret = 1'b1;
            end
            S_MEMWRITE: begin
                w_mv  = 1'b1;
                w_mw  = 1'b1;
                w_adr = 1'b1;
                w_ret = MemReady;
            end
            S_EXECR: begin
                w_sa     = SRCA_RD1;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                w_sa     = SRCA_RD1;
                w_sb     = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_rw  = 1'b1;
                w_ret = 1'b1;
            end
            // ALUResult carries OldPC+4 for the link while ALUOut holds the target
            S_JUMP: begin
                w_sa  = SRCA_OLDPC;
                w_sb  = SRCB_FOUR;
                w_pcw = 1'b1;
            end
            S_BRANCH: begin
                w_sa     = SRCA_RD1;
                w_alu_op = ALUOP_SUB;
                w_pcw    = BrTaken;
                w_ret    = 1'b1;
            end
            S_UPPER: begin
                w_sa = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                w_sb = SRCB_IMM;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_dec (
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .is_rtype   (r_state == S_EXECR),
        .alu_op     (w_alu_op),
        .ALUControl (w_alu_ctrl)
    );

    // Reset clears every output combinationally, so a pending access drops at once
    assign MemValid   = reset & w_mv;
    assign MemWrite   = reset & w_mw;
    assign AdrSrc     = reset & w_adr;
    assign IRWrite    = reset & w_irw;
    assign PCWrite    = reset & w_pcw;
    assign RegWrite   = reset & w_rw;
    assign ResultSrc  = reset ? w_rs : 2'b00;
    assign ALUSrcA    = reset ? w_sa : 2'b00;
    assign ALUSrcB    = reset ? w_sb : 2'b00;
    assign ImmSrc     = reset ? imm_src_of(op) : 3'b000;
    assign ALUControl = reset ? w_alu_ctrl : 4'b0000;
    assign Retire     = reset & w_ret;
    assign Illegal    = reset & (r_state == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction behavioural model producing the
// expected output vector of every cycle, plus directed literal checks.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mv, mw, adr, irw, pcw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ret, ill;
    } vec_t;

    logic       clk = 0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       BrTaken;
    logic       MemReady;
    logic       MemValid, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       Retire, Illegal;

    vec_t got, exp_v, snap;
    logic exp_on = 0;
    int   errors = 0;
    int   checks = 0;
    int   n, cpi_seen;
    logic [6:0] cur_op;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .BrTaken(BrTaken), .MemReady(MemReady),
        .MemValid(MemValid), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Retire(Retire),
        .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign got = {MemValid, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
                  Retire, Illegal};

    always @(negedge clk) begin
        if (exp_on) begin
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL cycle t=%0t got=%h exp=%h", $time, got, exp_v);
            end
        end
    end

    function automatic logic [2:0] imm_exp(logic [6:0] o);
        case (o)
            7'h23: return 3'd1;
            7'h63: return 3'd2;
            7'h6F: return 3'd3;
            7'h37, 7'h17: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] alu_exp(logic [2:0] f3, logic b30, logic isr);
        logic [3:0] t [8];
        t = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (f3 == 3'd0 && isr && b30) return 4'd1;
        if (f3 == 3'd5 && b30) return 4'd7;
        return t[f3];
    endfunction

    function automatic vec_t base(logic [6:0] o);
        vec_t e = '0;
        e.imm = imm_exp(o);
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    task automatic st(input logic mr, input logic bt, input vec_t e);
        MemReady = mr;
        BrTaken  = bt;
        exp_v    = e;
        exp_on   = 1;
        #2 snap  = got;
        n++;
        if (snap.ret && cpi_seen == 0) cpi_seen = n;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] g, input logic [31:0] x);
        checks++;
        if (g !== x) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, g, x);
        end
    endtask

    task automatic reset_for(input int k);
        reset = 0;
        for (int i = 0; i < k; i++) st(rb(), rb(), '0);
        reset = 1;
    endtask

    task automatic wb(input logic [6:0] o);
        vec_t e = base(o);
        e.rw = 1; e.ret = 1;
        st(rb(), rb(), e);
    endtask

    task automatic jump(input logic [6:0] o);
        vec_t e = base(o);
        e.sa = 1; e.sb = 2; e.pcw = 1;
        st(rb(), rb(), e);
    endtask

    task automatic do_instr(input logic [31:0] ins, input int fw, input int mwt,
                            input logic bt, input logic abort,
                            output int cpi, output vec_t xs);
        vec_t e;
        logic [6:0] o = ins[6:0];
        n = 0; cpi_seen = 0; xs = '0;
        e = base(cur_op);
        e.mv = 1; e.sb = 2; e.rs = 2;
        for (int i = 0; i < fw; i++) st(0, rb(), e);
        e.irw = 1; e.pcw = 1;
        st(1, rb(), e);
        op = o; funct3 = ins[14:12]; funct7b5 = ins[30]; cur_op = o;
        e = base(o); e.sa = 1; e.sb = 1;
        st(rb(), rb(), e);
        if (o == 7'h03 || o == 7'h23) begin
            e = base(o); e.sa = 2; e.sb = 1;
            st(rb(), rb(), e);
            e = base(o); e.mv = 1; e.adr = 1; e.mw = (o == 7'h23);
            for (int i = 0; i < mwt; i++) begin
                st(0, rb(), e);
                xs = snap;
                if (abort) begin
                    reset = 0;
                    #1 lit("rst_midread", 32'(got), 0);
                    reset_for(2);
                    cpi = 0;
                    return;
                end
            end
            if (o == 7'h03) begin
                st(1, rb(), e);
                e = base(o); e.rs = 1; e.rw = 1; e.ret = 1;
                st(rb(), rb(), e);
            end else begin
                e.ret = 1;
                st(1, rb(), e);
            end
        end else if (o == 7'h33 || o == 7'h13) begin
            e = base(o); e.sa = 2; e.sb = (o == 7'h13) ? 2'd1 : 2'd0;
            e.alu = alu_exp(ins[14:12], ins[30], o == 7'h33);
            st(rb(), rb(), e);
            xs = snap;
            wb(o);
        end else if (o == 7'h6F) begin
            jump(o);
            wb(o);
        end else if (o == 7'h67) begin
            e = base(o); e.sa = 2; e.sb = 1;
            st(rb(), rb(), e);
            jump(o);
            wb(o);
        end else if (o == 7'h63) begin
            e = base(o); e.sa = 2; e.alu = 4'd1; e.pcw = bt; e.ret = 1;
            st(rb(), bt, e);
            xs = snap;
        end else if (o == 7'h37 || o == 7'h17) begin
            e = base(o); e.sa = (o == 7'h37) ? 2'd3 : 2'd1; e.sb = 1;
            st(rb(), rb(), e);
            wb(o);
        end else begin
            e = base(o); e.ill = 1;
            for (int i = 0; i < 4; i++) st(rb(), rb(), e);
            xs = snap;
            reset_for(2);
        end
        cpi = cpi_seen;
    endtask

    initial begin
        int   c;
        vec_t x;
        logic [6:0] ops [9];
        logic [31:0] ins;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6F, 7'h67, 7'h63, 7'h37, 7'h17};
        reset = 0; MemReady = 0; BrTaken = 0;
        op = 0; funct3 = 0; funct7b5 = 0; cur_op = 0;
        @(posedge clk); #1;
        lit("reset_memvalid", 32'(MemValid), 0);
        reset_for(3);

        do_instr(32'h002081B3, 0, 0, 0, 0, c, x);
        lit("add_cpi", c, 4);
        lit("add_alu", 32'(x.alu), 0);
        do_instr(32'h402081B3, 1, 0, 0, 0, c, x);
        lit("sub_alu", 32'(x.alu), 1);
        do_instr(32'h4020D193, 0, 0, 0, 0, c, x);
        lit("srai_alu", 32'(x.alu), 7);
        do_instr(32'h40000093, 0, 0, 0, 0, c, x);
        lit("addi_b30_alu", 32'(x.alu), 0);
        do_instr(32'h0000A183, 0, 3, 0, 0, c, x);
        lit("lw_cpi", c, 8);
        lit("lw_wait_adr", 32'({x.mv, x.adr}), 3);
        do_instr(32'h00208463, 0, 0, 1, 0, c, x);
        lit("beq_taken_pcw", 32'(x.pcw), 1);
        lit("beq_cpi", c, 3);
        do_instr(32'h00208463, 0, 0, 0, 0, c, x);
        lit("beq_not_pcw", 32'(x.pcw), 0);
        do_instr(32'h000080E7, 0, 0, 0, 0, c, x);
        lit("jalr_cpi", c, 5);
        do_instr(32'h0020A223, 0, 0, 0, 0, c, x);
        lit("sw_cpi", c, 4);
        do_instr(32'h0000A183, 0, 2, 0, 1, c, x);
        do_instr(32'h002081B3, 0, 0, 0, 0, c, x);
        lit("add_after_rst_cpi", c, 4);
        do_instr(32'h0000007F, 0, 0, 0, 0, c, x);
        lit("trap_illegal", 32'(x.ill), 1);
        lit("trap_memvalid", 32'(x.mv), 0);

        for (int k = 0; k < 250; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 19) == 0)
                ins[6:0] = ($urandom % 2) ? 7'h7F : 7'h0F;
            else
                ins[6:0] = ops[$urandom_range(0, 8)];
            do_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                     rb(), ($urandom_range(0, 29) == 0), c, x);
        end

        exp_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
